// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
//   Groups the two handshakes of the fetch stage:
//     - instruction-memory request/response (imem_*)
//     - fetched-instruction valid/ready towards decode (instr*)
//   master : the fetch unit (drives imem_req/imem_addr and instr/instr_pc/instr_valid)
//   slave  : the environment (memory + decode) driving imem_ack/imem_rdata/instr_ready
//   ADDR_W must match the ADDR_W of the instr_fetch_unit it is bound to.
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 64
) ();
  // instruction memory side
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  // decode side
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr, instr_pc, instr_valid,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr, instr_pc, instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage: holds the PC, keeps at most one request outstanding to a
//   variable-latency instruction memory and hands each fetched word to decode
//   over a valid/ready handshake. Branch redirects update the PC; a fetch that
//   is in flight when a redirect arrives is discarded on its ack.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   fetch_en     allow new requests to be issued
//   br_taken     one-cycle redirect pulse
//   br_target    redirect address (low two bits ignored)
//   fetch_count  saturating count of instructions accepted by decode
//   bus          master side of instr_fetch_unit_if (imem_* and instr*)
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [CNT_W-1:0]  fetch_count,
  instr_fetch_unit_if.master bus
);

  localparam logic [1:0] ST_ISSUE = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  // Set when a redirect lands while a request is in flight; the matching
  // ack then carries wrong-path data and is dropped.
  logic              drop;

  // Redirect targets are forced onto a 4-byte boundary.
  logic [ADDR_W-1:0] br_pc;
  assign br_pc = br_target & ~ADDR_W'(3);

  // NOTE: every register here is assigned with <= so all updates take effect
  // together at the edge; a blocking = would let later statements see the new
  // value within the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled at the edge (synchronous), so rst_n is an ordinary
    // data input to these flops rather than an asynchronous set/clear.
    if (!rst_n) begin
      state           <= ST_ISSUE;
      pc              <= RESET_PC;
      drop            <= 1'b0;
      fetch_count     <= '0;
      bus.imem_req    <= 1'b0;
      bus.imem_addr   <= '0;
      bus.instr       <= '0;
      bus.instr_pc    <= '0;
      bus.instr_valid <= 1'b0;
    end else begin
      case (state)
        ST_ISSUE: begin
          // A redirect wins over issuing: the old pc is already wrong-path.
          if (br_taken) begin
            pc <= br_pc;
          end else if (fetch_en) begin
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= pc;
            state         <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          // The request is never retracted: imem_req/imem_addr hold until ack.
          if (bus.imem_ack) begin
            bus.imem_req <= 1'b0;
            if (drop || br_taken) begin
              drop  <= 1'b0;
              state <= ST_ISSUE;
              if (br_taken) pc <= br_pc;
            end else begin
              bus.instr       <= bus.imem_rdata;
              bus.instr_pc    <= bus.imem_addr;
              bus.instr_valid <= 1'b1;
              state           <= ST_HOLD;
            end
          end else if (br_taken) begin
            pc   <= br_pc;
            drop <= 1'b1;
          end
        end

        ST_HOLD: begin
          // A redirect discards the held instruction even if decode takes it
          // in the same cycle; it is not counted.
          if (br_taken) begin
            bus.instr_valid <= 1'b0;
            pc              <= br_pc;
            state           <= ST_ISSUE;
          end else if (bus.instr_ready) begin
            bus.instr_valid <= 1'b0;
            pc              <= pc + ADDR_W'(4);
            if (fetch_count != '1) fetch_count <= fetch_count + CNT_W'(1);
            state           <= ST_ISSUE;
          end
        end

        // NOTE: the default arm makes the case complete, so an unused state
        // encoding recovers to ISSUE instead of leaving the machine stuck.
        default: state <= ST_ISSUE;
      endcase
    end
  end

endmodule
